// File: rtl/lcd1602_bus_master.sv
// HD44780/LCD1602 bus initiator: turns one-cycle write requests into E/RS/RW
// write cycles, then polls the busy flag (or waits a fixed delay) before ready.
module lcd1602_bus_master #(
  parameter int T_AS         = 2,
  parameter int T_EH         = 12,
  parameter int T_EL         = 12,
  parameter int BUSY_TIMEOUT = 48000,
  parameter int NOPOLL_WAIT  = 120000
) (
  input  logic       in_clock,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic       wr_rs,
  input  logic       wr_nopoll,
  input  logic [7:0] wr_data,
  output logic       ready,
  output logic       timeout,
  output logic [6:0] bf_addr,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_d_out,
  output logic       lcd_d_oe,
  input  logic [7:0] lcd_d_in
);

  localparam int MAX_A = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int MAX_B = (MAX_A > T_EL) ? MAX_A : T_EL;
  localparam int MAX_P = (MAX_B > NOPOLL_WAIT) ? MAX_B : NOPOLL_WAIT;
  localparam int CW    = $clog2(MAX_P + 1);
  localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CW-1:0] AS_LD = CW'(T_AS - 1);
  localparam logic [CW-1:0] EH_LD = CW'(T_EH - 1);
  localparam logic [CW-1:0] EL_LD = CW'(T_EL - 1);
  localparam logic [CW-1:0] NW_LD = CW'(NOPOLL_WAIT - 1);
  localparam logic [TW-1:0] TMAX  = TW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_EHI   = 3'd2,
    W_ELO   = 3'd3,
    N_WAIT  = 3'd4,
    P_SETUP = 3'd5,
    P_EHI   = 3'd6,
    P_ELO   = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] tmr_inc_s;
  logic          last_s;
  logic          rs_lat_q, rs_lat_d;
  logic [7:0]    data_lat_q, data_lat_d;
  logic          nopoll_q, nopoll_d;
  logic          bf_q, bf_d;
  logic [6:0]    addr_q, addr_d;
  logic          timeout_q, timeout_d;
  logic          ready_q, ready_d;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic [7:0]    dout_q, dout_d;
  logic          oe_q, oe_d;

  assign ready     = ready_q;
  assign timeout   = timeout_q;
  assign bf_addr   = addr_q;
  assign lcd_e     = e_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = rw_q;
  assign lcd_d_out = dout_q;
  assign lcd_d_oe  = oe_q;

  // State, phase counters, latched request and registered pin values.
  always_ff @(posedge in_clock) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      rs_lat_q   <= 1'b0;
      data_lat_q <= 8'h00;
      nopoll_q   <= 1'b0;
      bf_q       <= 1'b0;
      addr_q     <= 7'h00;
      timeout_q  <= 1'b0;
      ready_q    <= 1'b1;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      dout_q     <= 8'h00;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      rs_lat_q   <= rs_lat_d;
      data_lat_q <= data_lat_d;
      nopoll_q   <= nopoll_d;
      bf_q       <= bf_d;
      addr_q     <= addr_d;
      timeout_q  <= timeout_d;
      ready_q    <= ready_d;
      e_q        <= e_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
    end
  end

  // Next-state sequencing; pin values are derived from the state being entered
  // so that every pin is a flop output aligned with its state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    rs_lat_d   = rs_lat_q;
    data_lat_d = data_lat_q;
    nopoll_d   = nopoll_q;
    bf_d       = bf_q;
    addr_d     = addr_q;
    timeout_d  = timeout_q;
    last_s     = (cnt_q == '0);
    tmr_inc_s  = (tmr_q == TMAX) ? tmr_q : tmr_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (wr_stb) begin
          rs_lat_d   = wr_rs;
          data_lat_d = wr_data;
          nopoll_d   = wr_nopoll;
          timeout_d  = 1'b0;
          state_d    = W_SETUP;
          cnt_d      = AS_LD;
        end else begin
          state_d = IDLE;
        end
      end
      W_SETUP: begin
        if (last_s) begin
          state_d = W_EHI;
          cnt_d   = EH_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      W_EHI: begin
        if (last_s) begin
          state_d = W_ELO;
          cnt_d   = EL_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      W_ELO: begin
        if (last_s && nopoll_q) begin
          state_d = N_WAIT;
          cnt_d   = NW_LD;
        end else if (last_s) begin
          state_d = P_SETUP;
          cnt_d   = AS_LD;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      N_WAIT: begin
        if (last_s) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      P_SETUP: begin
        tmr_d = tmr_inc_s;
        if (last_s) begin
          state_d = P_EHI;
          cnt_d   = EH_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      P_EHI: begin
        tmr_d = tmr_inc_s;
        if (last_s) begin
          bf_d    = lcd_d_in[7];
          addr_d  = lcd_d_in[6:0];
          state_d = P_ELO;
          cnt_d   = EL_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      P_ELO: begin
        tmr_d = tmr_inc_s;
        // The timer is only consulted here so the read cycle in flight always completes.
        if (!last_s) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!bf_q) begin
          state_d = IDLE;
        end else if (tmr_q < TMAX) begin
          state_d = P_SETUP;
          cnt_d   = AS_LD;
        end else begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d = 1'b0;
    e_d     = 1'b0;
    rs_d    = rs_q;
    rw_d    = 1'b0;
    dout_d  = dout_q;
    oe_d    = 1'b0;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
      end
      W_SETUP, W_EHI, W_ELO: begin
        rs_d   = rs_lat_d;
        dout_d = data_lat_d;
        oe_d   = 1'b1;
        e_d    = (state_d == W_EHI);
      end
      N_WAIT: begin
        e_d = 1'b0;
      end
      P_SETUP, P_EHI, P_ELO: begin
        rs_d = 1'b0;
        rw_d = 1'b1;
        e_d  = (state_d == P_EHI);
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd1602_bus_master.sv
// Randomised scoreboard bench for lcd1602_bus_master with a behavioural LCD
// responder and a transaction-level timing model.
module tb_lcd1602_bus_master;

  localparam int T_AS = 2;
  localparam int T_EH = 12;
  localparam int T_EL = 12;
  localparam int BT   = 1000;
  localparam int NW   = 300;
  localparam int PER  = T_AS + T_EH + T_EL;

  typedef struct {
    int         lat;
    int         polls;
    logic       rs;
    logic [7:0] data;
    logic       tmo;
    logic [6:0] addr;
  } exp_t;

  logic       in_clock = 1'b0;
  logic       rst = 1'b1;
  logic       wr_stb = 1'b0;
  logic       wr_rs = 1'b0;
  logic       wr_nopoll = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ready, timeout, lcd_e, lcd_rs, lcd_rw, lcd_d_oe;
  logic [6:0] bf_addr;
  logic [7:0] lcd_d_out, lcd_d_in;

  int         n_vec = 0;
  int         n_bad = 0;
  exp_t       exp_q[$];
  logic [6:0] model_addr = 7'h00;

  int         reads_total = 0;
  int         read_base = 0;
  int         busy_n_cur = 0;
  logic [6:0] addr_cur = 7'h00;
  logic       e_prev = 1'b0;
  logic       busy_s;

  lcd1602_bus_master #(
    .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL), .BUSY_TIMEOUT(BT), .NOPOLL_WAIT(NW)
  ) dut (
    .in_clock(in_clock), .rst(rst), .wr_stb(wr_stb), .wr_rs(wr_rs),
    .wr_nopoll(wr_nopoll), .wr_data(wr_data), .ready(ready), .timeout(timeout),
    .bf_addr(bf_addr), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_d_out(lcd_d_out), .lcd_d_oe(lcd_d_oe), .lcd_d_in(lcd_d_in)
  );

  always #5 in_clock = ~in_clock;

  // LCD responder: reports busy for the first busy_n_cur reads of each write.
  assign busy_s   = ((reads_total - read_base) < busy_n_cur);
  assign lcd_d_in = {busy_s, addr_cur};

  always @(negedge in_clock) begin
    if (e_prev && !lcd_e && lcd_rw) reads_total <= reads_total + 1;
    e_prev <= lcd_e;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: one write cycle, then either a fixed wait or read polls
  // until the LCD reports not-busy or the poll time budget is spent.
  function automatic exp_t model(input logic rs, input logic [7:0] d, input logic np,
                                 input int bn, input logic [6:0] a, input logic [6:0] prev);
    exp_t e;
    e.rs = rs; e.data = d; e.tmo = 1'b0;
    if (np) begin
      e.polls = 0; e.lat = PER + NW; e.addr = prev;
    end else begin
      e.polls = 0;
      for (int n = 1; n <= 100000; n++) begin
        e.polls = n;
        if (n > bn) break;
        if (PER * n >= BT) begin
          e.tmo = 1'b1;
          break;
        end
      end
      e.lat  = PER + PER * e.polls;
      e.addr = a;
    end
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1) begin
      @(negedge in_clock);
      n++;
      if (n > 5000) begin
        $display("FAIL wait_ready: ready=%b after %0d cycles, expected 1", ready, n);
        $fatal(1);
      end
    end
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, input logic np,
                          input int bn, input logic [6:0] a, input logic junk);
    exp_t e;
    @(negedge in_clock);
    wait_ready();
    busy_n_cur = bn;
    addr_cur   = a;
    read_base  = reads_total;
    e = model(rs, d, np, bn, a, model_addr);
    model_addr = e.addr;
    exp_q.push_back(e);
    wr_stb = 1'b1; wr_rs = rs; wr_data = d; wr_nopoll = np;
    @(negedge in_clock);
    wr_stb = 1'b0; wr_rs = 1'($urandom); wr_data = 8'($urandom); wr_nopoll = 1'($urandom);
    if (junk) begin
      for (int i = 0; i < 3; i++) begin
        wr_stb = 1'b1; wr_data = 8'($urandom); wr_rs = 1'($urandom); wr_nopoll = 1'($urandom);
        @(negedge in_clock);
      end
      wr_stb = 1'b0;
    end
  endtask

  // Monitor: tracks bus activity per transaction and scores it at ready rise.
  initial begin : monitor
    int         cyc = 0, start = 0, e_rise = 0, last_rd = 0, wr_p = 0, rd_p = 0, wr_off = 0;
    logic       pr = 1'b1, pe = 1'b0, in_txn = 1'b0, wbad = 1'b0, sbad = 1'b0, obad = 1'b0;
    logic [7:0] wd = 8'h00;
    logic       wrs = 1'b0, woe = 1'b0;
    exp_t       e;
    forever begin
      @(posedge in_clock);
      #1;
      cyc++;
      if (rst) begin
        check("rst_ready", int'(ready), 1);
        check("rst_e", int'(lcd_e), 0);
        check("rst_rw", int'(lcd_rw), 0);
        check("rst_oe", int'(lcd_d_oe), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_bf_addr", int'(bf_addr), 0);
        in_txn = 1'b0;
      end else begin
        if (pr && !ready) begin
          in_txn = 1'b1; start = cyc; wr_p = 0; rd_p = 0;
          wbad = 1'b0; sbad = 1'b0; obad = 1'b0;
          check("timeout_cleared", int'(timeout), 0);
        end
        if (lcd_d_oe && lcd_rw) obad = 1'b1;
        if (!pe && lcd_e) begin
          e_rise = cyc;
          if (!lcd_rw) begin
            wr_p++; wd = lcd_d_out; wrs = lcd_rs; woe = lcd_d_oe; wr_off = cyc - start;
          end else begin
            rd_p++;
            if (rd_p > 1 && (cyc - last_rd) != PER) sbad = 1'b1;
            last_rd = cyc;
          end
        end
        if (pe && !lcd_e && (cyc - e_rise) != T_EH) wbad = 1'b1;
        if (!pr && ready && in_txn) begin
          in_txn = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_txn", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("latency", cyc - start, e.lat);
            check("write_pulses", wr_p, 1);
            check("write_data", int'(wd), int'(e.data));
            check("write_rs", int'(wrs), int'(e.rs));
            check("write_oe", int'(woe), 1);
            check("e_rise_offset", wr_off, T_AS);
            check("read_polls", rd_p, e.polls);
            check("e_width", int'(wbad), 0);
            check("poll_spacing", int'(sbad), 0);
            check("oe_rw_overlap", int'(obad), 0);
            check("timeout", int'(timeout), int'(e.tmo));
            check("bf_addr", int'(bf_addr), int'(e.addr));
          end
        end
      end
      pr = ready;
      pe = lcd_e;
    end
  end

  initial begin : driver
    int n;
    rst = 1'b1;
    repeat (3) @(negedge in_clock);
    rst = 1'b0;

    do_write(1'b0, 8'h38, 1'b0, 0, 7'h05, 1'b0);
    do_write(1'b1, 8'h41, 1'b0, 3, 7'h12, 1'b1);
    do_write(1'b0, 8'h01, 1'b0, 1000000, 7'h00, 1'b0);
    do_write(1'b1, 8'h5a, 1'b0, 0, 7'h27, 1'b0);
    do_write(1'b0, 8'h30, 1'b1, 0, 7'h44, 1'b0);
    for (int i = 0; i < 12; i++) begin
      do_write(1'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0),
               $urandom_range(0, 4), 7'($urandom), 1'($urandom));
    end

    // Reset in the middle of the write E pulse; a strobe during reset is dropped.
    @(negedge in_clock);
    wait_ready();
    busy_n_cur = 0;
    wr_stb = 1'b1; wr_rs = 1'b1; wr_data = 8'ha5; wr_nopoll = 1'b0;
    @(negedge in_clock);
    wr_stb = 1'b0;
    n = 0;
    while (lcd_e !== 1'b1) begin
      @(negedge in_clock);
      n++;
      if (n > 20) begin
        $display("FAIL wait_e: lcd_e=%b after %0d cycles, expected 1", lcd_e, n);
        $fatal(1);
      end
    end
    repeat (3) @(negedge in_clock);
    rst = 1'b1; wr_stb = 1'b1;
    @(negedge in_clock);
    rst = 1'b0; wr_stb = 1'b0;
    model_addr = 7'h00;

    do_write(1'b1, 8'h7e, 1'b1, 0, 7'h33, 1'b0);
    do_write(1'b0, 8'h80, 1'b0, 1, 7'h40, 1'b0);
    @(negedge in_clock);
    wait_ready();
    repeat (3) @(negedge in_clock);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
